wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//   Shares the register file's single write-back port (rd_wb / write_data_register_wb / regwrite_wb)
//   between the in-order pipeline write-back and the multi-cycle FPU result stream.
//   FPU results are buffered in a small FIFO. The pipeline has fixed priority, with a starvation
//   counter that forces an FPU drain slot. Sits between the WB stage / FPU and registerfile.
// PARAMETERS
//   FIFO_DEPTH    4   FPU result FIFO entries (power of 2, >=2)
//   STARVE_LIMIT  8   cycles a non-empty FIFO may wait before a drain slot is forced (>=1)
// PORTS
//   clk                     in   1   system clock, all state on posedge
//   rstn                    in   1   asynchronous active-low reset
//   pipe_valid              in   1   pipeline WB result present this cycle
//   pipe_rd                 in   5   pipeline destination register
//   pipe_data               in   32  pipeline result
//   pipe_regwrite           in   2   00 none, 01 int file, 10 fpu file, 11 illegal (treated as 00)
//   pipe_ready              out  1   pipeline result accepted; low = pipeline must stall WB
//   fpu_valid               in   1   FPU result offered
//   fpu_rd                  in   5   FPU destination register
//   fpu_data                in   32  FPU result
//   fpu_regwrite            in   2   01 int (fcmp/fcvt) or 10 fpu; 00/11 accepted, then dropped
//   fpu_ready               out  1   FIFO can accept (count < FIFO_DEPTH)
//   rd_wb                   out  5   registered write address to registerfile
//   write_data_register_wb  out  32  registered write data
//   regwrite_wb             out  2   registered write enable/select (00/01/10)
//   fifo_count              out  log2(FIFO_DEPTH)+1   current FIFO occupancy
// BEHAVIOUR
//   Reset (async, rstn=0)
//     - rd_wb=0, write_data_register_wb=0, regwrite_wb=00; FIFO emptied; fifo_count=0; starve_cnt=0.
//     - Reset mid-operation discards buffered FPU results; no write is issued for them.
//   FIFO push
//     - fpu_valid && fpu_ready pushes {rd,data,regwrite}. fpu_ready = (fifo_count < FIFO_DEPTH).
//     - fpu_ready is based on registered count only: no push-while-full even if a pop occurs that cycle.
//     - No bypass: a pushed entry is eligible to drain from the next cycle.
//     - FPU result-to-write latency is therefore >=2 cycles.
//   Starvation
//     - force_fpu = (fifo_count != 0) && (starve_cnt >= STARVE_LIMIT).
//     - starve_cnt: cleared on pop or when FIFO is empty; otherwise +1, saturating at STARVE_LIMIT.
//   Grant, per cycle (priority order)
//     1. force_fpu                     -> pop FIFO head; pipe_ready=0.
//     2. pipe_valid && pipe writes     -> issue pipe result; FIFO waits.
//     3. FIFO non-empty                -> pop FIFO head; a pipe entry with no write is still accepted.
//     4. otherwise idle (regwrite_wb <= 00 next cycle).
//     - "Pipe writes" means pipe_regwrite is 01 or 10.
//     - pipe_ready = !force_fpu (combinational from registered state).
//     - A pipe_valid with no write never occupies the port.
//   Output register
//     - The granted source's {rd,data,regwrite} is registered: writes appear on the *_wb outputs
//       exactly 1 cycle after grant, for 1 cycle only.
//   Write filtering (applied at the output register)
//     - An int write (01) to rd=0 is issued as regwrite_wb=00; x0 stays 0. FPU-file f0 is writable.
//     - An 11 code, or 00 from the FPU, is issued as 00 but still consumes its FIFO slot / grant.
//   Ordering and scope
//     - FIFO results drain in order. No ordering is enforced between pipe and FPU streams.
//     - WAW/RAW between the two streams is the upstream scoreboard's job, not this block's.
//   Simultaneous events
//     - Push and pop in the same cycle: count is unchanged.
//     - fifo_count wraps never; pointers wrap modulo FIFO_DEPTH.
// TESTING
//   - Reset: hold rstn=0 with fpu_valid=1 -> fpu_ready irrelevant; fifo_count=0, regwrite_wb=00.
//     Release -> first FPU push seen 2 cycles later on regwrite_wb.
//   - Pipe only: pipe_valid=1, rd=5, data=32'h1234, regwrite=01 -> next cycle rd_wb=5,
//     data=32'h1234, regwrite_wb=01; pipe_ready stays 1.
//   - Starvation: FPU pushes rd=3, data=32'h3F800000, 10 while pipe writes every cycle ->
//     pipe_ready=0 in exactly one cycle after STARVE_LIMIT=8 waits; FPU write then appears
//     next cycle with regwrite_wb=10.
//   - Full FIFO: 4 FPU pushes, pipe busy -> fifo_count=4, fpu_ready=0. 5th fpu_valid is not accepted;
//     after one pop fpu_ready=1; all 4 drain in push order.
//   - Bubble drain: pipe_valid=1, regwrite=00 with a FIFO entry -> pipe_ready=1 and FIFO pops the same cycle.
//   - x0 filter: pipe rd=0, regwrite=01 -> regwrite_wb=00. FPU rd=0, regwrite=10 -> regwrite_wb=10.
//   - Mid-op reset: 3 entries queued, pulse rstn low -> fifo_count=0; no stale write after release.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// wb_port_arbiter : shares the register-file write-back port between the
// pipeline WB stage and a FIFO-buffered FPU result stream.   rev 1.0
// ============================================================================
module wb_port_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        pipe_valid,
    input  logic [4:0]                  pipe_rd,
    input  logic [31:0]                 pipe_data,
    input  logic [1:0]                  pipe_regwrite,
    output logic                        pipe_ready,
    input  logic                        fpu_valid,
    input  logic [4:0]                  fpu_rd,
    input  logic [31:0]                 fpu_data,
    input  logic [1:0]                  fpu_regwrite,
    output logic                        fpu_ready,
    output logic [4:0]                  rd_wb,
    output logic [31:0]                 write_data_register_wb,
    output logic [1:0]                  regwrite_wb,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // Entry layout: {rd[38:34], data[33:2], regwrite[1:0]}
    logic [38:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [SW-1:0] starve_cnt;

    logic        fifo_empty;
    logic        force_fpu;
    logic        pipe_writes;
    logic        grant_pipe;
    logic        pop;
    logic        push;
    logic        issue;
    logic [38:0] head;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    logic [1:0]  sel_rw;
    logic [1:0]  filt_rw;

    always_comb begin
        fifo_empty  = (fifo_count == '0);
        fpu_ready   = (fifo_count < CW'(FIFO_DEPTH));
        force_fpu   = !fifo_empty && (starve_cnt >= SW'(STARVE_LIMIT));
        pipe_writes = pipe_valid && ((pipe_regwrite == 2'b01) || (pipe_regwrite == 2'b10));
        pipe_ready  = !force_fpu;
        grant_pipe  = !force_fpu && pipe_writes;
        // Any cycle the pipe does not claim the port is a drain slot.
        pop         = !fifo_empty && !grant_pipe;
        push        = fpu_valid && fpu_ready;
        issue       = grant_pipe || pop;
        head        = mem[rd_ptr];
        sel_rd      = grant_pipe ? pipe_rd       : head[38:34];
        sel_data    = grant_pipe ? pipe_data     : head[33:2];
        sel_rw      = grant_pipe ? pipe_regwrite : head[1:0];
        filt_rw     = 2'b00;
        if (sel_rw == 2'b10)
            filt_rw = 2'b10;
        else if (sel_rw == 2'b01 && sel_rd != 5'd0)
            filt_rw = 2'b01;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {fpu_rd, fpu_data, fpu_regwrite};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            fifo_count             <= '0;
            starve_cnt             <= '0;
            rd_wb                  <= '0;
            write_data_register_wb <= '0;
            regwrite_wb            <= 2'b00;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (pop || fifo_empty)
                starve_cnt <= '0;
            else if (starve_cnt < SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + SW'(1);

            if (issue) begin
                rd_wb                  <= sel_rd;
                write_data_register_wb <= sel_data;
                regwrite_wb            <= filt_rw;
            end else begin
                regwrite_wb            <= 2'b00;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// Directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic [1:0]  pipe_regwrite;
    logic        pipe_ready;
    logic        fpu_valid;
    logic [4:0]  fpu_rd;
    logic [31:0] fpu_data;
    logic [1:0]  fpu_regwrite;
    logic        fpu_ready;
    logic [4:0]  rd_wb;
    logic [31:0] write_data_register_wb;
    logic [1:0]  regwrite_wb;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    wb_port_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .pipe_valid             (pipe_valid),
        .pipe_rd                (pipe_rd),
        .pipe_data              (pipe_data),
        .pipe_regwrite          (pipe_regwrite),
        .pipe_ready             (pipe_ready),
        .fpu_valid              (fpu_valid),
        .fpu_rd                 (fpu_rd),
        .fpu_data               (fpu_data),
        .fpu_regwrite           (fpu_regwrite),
        .fpu_ready              (fpu_ready),
        .rd_wb                  (rd_wb),
        .write_data_register_wb (write_data_register_wb),
        .regwrite_wb            (regwrite_wb),
        .fifo_count             (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic [4:0] rd, input logic [31:0] d,
                            input logic [1:0] rw);
        check_eq({tag, ".rd"}, 64'(rd_wb), 64'(rd));
        check_eq({tag, ".data"}, 64'(write_data_register_wb), 64'(d));
        check_eq({tag, ".rw"}, 64'(regwrite_wb), 64'(rw));
    endtask

    initial begin
        rstn = 1'b0;
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0; pipe_regwrite = 2'b00;
        fpu_valid = 1'b1; fpu_rd = 5'd7; fpu_data = 32'hAAAA_0001; fpu_regwrite = 2'b10;

        // Reset held with an FPU result offered
        tick(); tick();
        check_wb("rst", 5'd0, 32'd0, 2'b00);
        check_eq("rst.count", 64'(fifo_count), 64'd0);
        rstn = 1'b1;
        tick();
        fpu_valid = 1'b0;
        check_eq("first.count", 64'(fifo_count), 64'd1);
        check_eq("first.rw_early", 64'(regwrite_wb), 64'd0);
        tick();
        check_wb("first", 5'd7, 32'hAAAA_0001, 2'b10);
        check_eq("first.count0", 64'(fifo_count), 64'd0);
        tick();
        check_eq("first.idle", 64'(regwrite_wb), 64'd0);

        // Pipe only
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1234; pipe_regwrite = 2'b01;
        check_eq("pipe.ready", 64'(pipe_ready), 64'd1);
        tick();
        check_wb("pipe", 5'd5, 32'h1234, 2'b01);
        check_eq("pipe.ready2", 64'(pipe_ready), 64'd1);

        // x0 filter on the pipe path
        pipe_rd = 5'd0; pipe_data = 32'hDEAD;
        tick();
        check_eq("x0.pipe.rw", 64'(regwrite_wb), 64'd0);
        pipe_valid = 1'b0;

        // f0 is writable via FPU path
        fpu_valid = 1'b1; fpu_rd = 5'd0; fpu_data = 32'h4000_0000; fpu_regwrite = 2'b10;
        tick();
        fpu_valid = 1'b0;
        tick();
        check_wb("f0", 5'd0, 32'h4000_0000, 2'b10);

        // FPU code 11 consumes its slot but writes nothing
        fpu_valid = 1'b1; fpu_rd = 5'd6; fpu_data = 32'h77; fpu_regwrite = 2'b11;
        tick();
        fpu_valid = 1'b0;
        tick();
        check_eq("fpu11.rw", 64'(regwrite_wb), 64'd0);
        check_eq("fpu11.count", 64'(fifo_count), 64'd0);

        // Starvation: pipe writes every cycle
        pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h55; pipe_regwrite = 2'b01;
        fpu_valid = 1'b1; fpu_rd = 5'd3; fpu_data = 32'h3F80_0000; fpu_regwrite = 2'b10;
        tick();
        fpu_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq($sformatf("starve.ready%0d", i), 64'(pipe_ready), (i == 8) ? 64'd0 : 64'd1);
        end
        check_wb("starve.pipe", 5'd9, 32'h55, 2'b01);
        tick();
        check_wb("starve.fpu", 5'd3, 32'h3F80_0000, 2'b10);
        check_eq("starve.ready_back", 64'(pipe_ready), 64'd1);

        // Full FIFO with pipe busy
        for (int i = 0; i < 4; i++) begin
            fpu_valid = 1'b1; fpu_rd = 5'(11 + i); fpu_data = 32'(256 + i); fpu_regwrite = 2'b10;
            tick();
        end
        check_eq("full.count", 64'(fifo_count), 64'd4);
        check_eq("full.ready", 64'(fpu_ready), 64'd0);
        fpu_rd = 5'd15; fpu_data = 32'h999;
        tick();
        fpu_valid = 1'b0;
        check_eq("full.count5", 64'(fifo_count), 64'd4);
        pipe_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_wb($sformatf("drain%0d", i), 5'(11 + i), 32'(256 + i), 2'b10);
            if (i == 0)
                check_eq("drain.ready", 64'(fpu_ready), 64'd1);
        end
        check_eq("drain.count", 64'(fifo_count), 64'd0);

        // Bubble drain
        fpu_valid = 1'b1; fpu_rd = 5'd20; fpu_data = 32'hBEEF; fpu_regwrite = 2'b01;
        tick();
        fpu_valid = 1'b0;
        pipe_valid = 1'b1; pipe_rd = 5'd21; pipe_data = 32'h1; pipe_regwrite = 2'b00;
        check_eq("bubble.ready", 64'(pipe_ready), 64'd1);
        check_eq("bubble.count", 64'(fifo_count), 64'd1);
        tick();
        check_wb("bubble", 5'd20, 32'hBEEF, 2'b01);
        check_eq("bubble.count0", 64'(fifo_count), 64'd0);

        // Mid-operation reset with 3 entries queued
        pipe_regwrite = 2'b01;
        for (int i = 0; i < 3; i++) begin
            fpu_valid = 1'b1; fpu_rd = 5'(24 + i); fpu_data = 32'(i); fpu_regwrite = 2'b10;
            tick();
        end
        fpu_valid = 1'b0; pipe_valid = 1'b0;
        check_eq("midrst.pre", 64'(fifo_count), 64'd3);
        #2 rstn = 1'b0;
        #1;
        check_eq("midrst.count", 64'(fifo_count), 64'd0);
        check_eq("midrst.rw", 64'(regwrite_wb), 64'd0);
        #1 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("midrst.stale%0d", i), 64'(regwrite_wb), 64'd0);
        end
        check_eq("midrst.count_end", 64'(fifo_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
